// File: rtl/mmcm_seq_pkg.sv
// Shared definitions for the MMCM reset sequencer.
// Provides the state encoding (as driven on state_o), the state_o width and a
// small helper used to size the shared cycle timer.
package mmcm_seq_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_RESET_MMCM = 3'd0,
        ST_WAIT_LOCK  = 3'd1,
        ST_STABILIZE  = 3'd2,
        ST_RUN        = 3'd3,
        ST_FAULT      = 3'd4
    } state_e;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/mmcm_reset_sequencer_if.sv
// Status/control bundle between the MMCM reset sequencer and its surroundings.
//   mmcm_locked_i   : MMCM LOCKED (asynchronous)
//   restart_i       : single-cycle sequence restart request
//   mmcm_rst_o      : MMCM RST pin
//   sys_rst_o       : active-high synchronous reset for downstream logic
//   ready_o/fault_o : RUN / FAULT indicators
//   state_o         : current state encoding
//   retry_cnt_o     : failed attempts since last lock or restart
//   lock_loss_cnt_o : lock losses seen in RUN (saturating)
// master = the sequencer, slave = the logic around it.
interface mmcm_reset_sequencer_if;
    import mmcm_seq_pkg::*;

    logic               mmcm_locked_i;
    logic               restart_i;
    logic               mmcm_rst_o;
    logic               sys_rst_o;
    logic               ready_o;
    logic               fault_o;
    logic [STATE_W-1:0] state_o;
    logic [7:0]         retry_cnt_o;
    logic [7:0]         lock_loss_cnt_o;

    modport master (
        input  mmcm_locked_i,
        input  restart_i,
        output mmcm_rst_o,
        output sys_rst_o,
        output ready_o,
        output fault_o,
        output state_o,
        output retry_cnt_o,
        output lock_loss_cnt_o
    );

    modport slave (
        output mmcm_locked_i,
        output restart_i,
        input  mmcm_rst_o,
        input  sys_rst_o,
        input  ready_o,
        input  fault_o,
        input  state_o,
        input  retry_cnt_o,
        input  lock_loss_cnt_o
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-stage synchronizer for a single asynchronous status bit.
//   clk_i : destination clock
//   rst_i : synchronous active-high reset, clears both stages
//   d_i   : asynchronous input
//   q_o   : synchronized output, two cycles of latency
module sync_2ff (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/mmcm_reset_sequencer.sv
// Supervises the system MMCM from the free-running 80 MHz board clock: pulses
// MMCM RST, waits for LOCKED, requires LOCKED to stay stable before releasing
// the downstream reset, retries on timeout / glitches and parks the MMCM in
// reset (FAULT) after too many failed attempts.
//   clk_80MHz_i : free-running board clock
//   rst_i       : synchronous active-high reset
//   bus         : status/control bundle (master side)
module mmcm_reset_sequencer
    import mmcm_seq_pkg::*;
#(
    parameter int unsigned RST_PULSE_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 80000,
    parameter int unsigned LOCK_STABLE_CYCLES  = 256,
    parameter int unsigned MAX_RETRIES         = 7
) (
    input logic                    clk_80MHz_i,
    input logic                    rst_i,
    mmcm_reset_sequencer_if.master bus
);

    localparam int unsigned CNT_MAX =
        max3(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);
    localparam int unsigned CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [7:0]       RETRY_LIMIT  = 8'(MAX_RETRIES);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       retry_q, retry_d;
    logic [7:0]       loss_q, loss_d;
    logic             mmcm_rst_q, mmcm_rst_d;
    logic             sys_rst_q, sys_rst_d;
    logic             ready_q, ready_d;
    logic             fault_q, fault_d;
    logic             locked_s;
    logic             fail;

    sync_2ff u_sync_locked (
        .clk_i (clk_80MHz_i),
        .rst_i (rst_i),
        .d_i   (bus.mmcm_locked_i),
        .q_o   (locked_s)
    );

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        loss_d  = loss_q;
        fail    = 1'b0;

        if (bus.restart_i) begin
            state_d = ST_RESET_MMCM;
            retry_d = '0;
        end else begin
            unique case (state_q)
                ST_RESET_MMCM: begin
                    if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
                end
                ST_WAIT_LOCK: begin
                    // Lock beats a coincident timeout.
                    if (locked_s)                   state_d = ST_STABILIZE;
                    else if (cnt_q == TIMEOUT_LAST) fail    = 1'b1;
                end
                ST_STABILIZE: begin
                    if (!locked_s) begin
                        fail = 1'b1;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = ST_RUN;
                        retry_d = '0;
                    end
                end
                ST_RUN: begin
                    if (!locked_s) begin
                        state_d = ST_RESET_MMCM;
                        retry_d = '0;
                        if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
                    end
                end
                ST_FAULT: ;
                default: state_d = ST_RESET_MMCM;
            endcase

            if (fail) begin
                retry_d = retry_q + 8'd1;
                state_d = (retry_d == RETRY_LIMIT) ? ST_FAULT : ST_RESET_MMCM;
            end
        end

        // Restart re-arms the timer even when already in RESET_MMCM.
        if (bus.restart_i || (state_d != state_q)) begin
            cnt_d = '0;
        end else if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end

        // Outputs are registered from the next state so they track state_o.
        mmcm_rst_d = (state_d == ST_RESET_MMCM) || (state_d == ST_FAULT);
        sys_rst_d  = (state_d != ST_RUN);
        ready_d    = (state_d == ST_RUN);
        fault_d    = (state_d == ST_FAULT);
    end

    always_ff @(posedge clk_80MHz_i) begin
        if (rst_i) begin
            state_q    <= ST_RESET_MMCM;
            cnt_q      <= '0;
            retry_q    <= '0;
            loss_q     <= '0;
            mmcm_rst_q <= 1'b1;
            sys_rst_q  <= 1'b1;
            ready_q    <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            retry_q    <= retry_d;
            loss_q     <= loss_d;
            mmcm_rst_q <= mmcm_rst_d;
            sys_rst_q  <= sys_rst_d;
            ready_q    <= ready_d;
            fault_q    <= fault_d;
        end
    end

    assign bus.mmcm_rst_o      = mmcm_rst_q;
    assign bus.sys_rst_o       = sys_rst_q;
    assign bus.ready_o         = ready_q;
    assign bus.fault_o         = fault_q;
    assign bus.state_o         = state_q;
    assign bus.retry_cnt_o     = retry_q;
    assign bus.lock_loss_cnt_o = loss_q;

endmodule
